// File: rtl/md_hazard_ctrl.sv
// Hazard detection for the D->E boundary plus sequencing of the shared
// multiply/divide unit (busy period, HI/LO write strobe, protocol error flag).
module md_hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       md_start_E,
  input  logic       md_is_div_E,
  input  logic       md_use_D,
  input  logic       ld_E,
  input  logic [4:0] A3_E,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic       use_rs_D,
  input  logic       use_rt_D,
  output logic       Stall,
  output logic       Flush_E,
  output logic       md_busy,
  output logic       hilo_we,
  output logic       md_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             md_err_nxt;
  logic             load_use;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      md_err <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      md_err <= md_err_nxt;
    end
  end

  // A start while BUSY (including its final cycle) is flagged and otherwise ignored.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    md_err_nxt = md_err;
    case (state)
      IDLE: begin
        if (md_start_E) begin
          state_nxt = BUSY;
          cnt_nxt   = md_is_div_E ? DIV_LOAD : MULT_LOAD;
        end
      end
      BUSY: begin
        if (md_start_E) md_err_nxt = 1'b1;
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    hilo_we  = (state == BUSY) && (cnt == '0);
    md_busy  = (state == BUSY) || md_start_E;
    load_use = ld_E && (A3_E != 5'd0) &&
               ((use_rs_D && (rs_D == A3_E)) || (use_rt_D && (rt_D == A3_E)));
    Stall    = load_use || (md_use_D && md_busy);
    Flush_E  = Stall;
  end

endmodule
